id_issue: RTL and testbench
===========================

ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 Parameter DATA_W, default 16, datapath/operand width (>=16).
REQ-002 Parameter FWD_EN, default 1; 1 = EX/MEM forwarding, 0 = interlock-only (stall until hazard retires).
REQ-003 clk  in  1  rising-edge clock; one clock domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_valid_i  in  1  instruction present; if_ready_o  out  1  instruction accepted this cycle.
REQ-006 pc_i  in  16  PC of instruction (already incremented); inst_i  in  16  instruction word.
REQ-007 rf_raddr0_o / rf_raddr1_o  out  4 each; rf_rdata0_i / rf_rdata1_i  in  DATA_W each; combinational regfile read, addr 0-7 GPR, 8 SP, 9 T, 10 IH.
REQ-008 mem_we_i  in  1, mem_waddr_i  in  4, mem_wdata_i  in  DATA_W: MEM-stage writeback source.
REQ-009 hold_i  in  1  downstream stall; ID/EX register holds contents.
REQ-010 ex_valid_o 1, ex_aluop_o 3, ex_op0_o DATA_W, ex_op1_o DATA_W, ex_sdata_o DATA_W, ex_we_o 1, ex_waddr_o 4, ex_is_load_o 1: registered ID/EX outputs.
REQ-011 ex_wdata_i  in  DATA_W: EX result of instruction currently in ID/EX, for forwarding.
REQ-012 branch_flag_o  out  1, branch_addr_o  out  16: combinational redirect, valid only when if_ready_o=1.

Function
REQ-013 Decode: NOP 00001; B 00010 (imm11 sext); BEQZ 00100/BNEZ 00101 (rx, imm8 sext); ADDIU 01001 (rx+=imm8 sext); LI 01101 (rx=imm8 zext); LW 10011 (ry=M[rx+imm5 sext]); SW 11011 (M[rx+imm5 sext]=ry); 11100 op[1:0]=01 ADDU, 11 SUBU (rz=rx op ry); 11101 op[4:0]=01010 CMP (T = rx==ry?0:1). Any other word decodes as NOP bubble (ex_valid_o=1, ex_we_o=0, aluop 0).
REQ-014 aluop: 0 NOP, 1 ADD, 2 SUB, 3 CMP, 4 PASS op0, 5 LOAD addr, 6 STORE addr.
REQ-015 Immediates sign/zero extended to DATA_W; branch target = pc_i + sext(imm) modulo 2^16.
REQ-016 Operand source priority per read port: ID/EX (ex_valid_o & ex_we_o & addr match & !ex_is_load_o) -> ex_wdata_i; else MEM match -> mem_wdata_i; else regfile. Applies only when FWD_EN=1 and port used.
REQ-017 Load-use: port used and ID/EX holds valid load with ex_waddr_o equal -> hazard; 1 cycle bubble.
REQ-018 FWD_EN=0: any used port matching a valid ID/EX or MEM write -> hazard; stall persists until no match.
REQ-019 if_ready_o = !hazard & !hold_i. Branch condition evaluated on forwarded rx; branch_flag_o=0 while if_ready_o=0.
REQ-020 Each edge: hold_i=1 -> ID/EX unchanged; else hazard or !if_valid_i -> bubble (ex_valid_o=0, ex_we_o=0, ex_is_load_o=0); else load decoded instruction.
REQ-021 Branches/B write nothing (bubble-equivalent, ex_valid_o=1, ex_we_o=0); delay-slot instruction issues normally.
REQ-022 Hazard and hold_i simultaneous: hold wins, nothing accepted, ID/EX unchanged.
REQ-023 Issue latency: accepted instruction visible on ex_* outputs one clock later.

Reset
REQ-024 rst=1 immediately forces all ex_* outputs to 0; branch_flag_o=0, branch_addr_o=0, if_ready_o=0 while rst=1.
REQ-025 Reset mid-stall discards the stalled instruction; first cycle after release shows no hazard.

Verification
REQ-026 LI R1,0x7F then ADDIU R1,0x01 back-to-back -> second issue ex_op0_o=0x007F (EX forward), ex_op1_o=1, no stall.
REQ-027 LW R2,[R3+0] then ADDU R2,R4,R5 -> if_ready_o=0 one cycle, one bubble, ADDU gets mem_wdata_i on retry.
REQ-028 FWD_EN=0, ADDIU R1 then SUBU R1,R1,R2 -> two stall cycles, then regfile value used.
REQ-029 BEQZ R0,imm=0xFE at pc_i=0x0010 with R0=0 -> branch_flag_o=1, branch_addr_o=0x000E; R0=5 -> flag 0.
REQ-030 hold_i=1 during load-use hazard for 3 cycles -> ID/EX frozen, if_ready_o=0, afterwards single bubble then issue.
REQ-031 Assert rst mid-stall -> all ex_* zero asynchronously; post-reset NOP issues with ex_we_o=0.

Source files
------------

// File: rtl/id_issue.sv
// id_issue: decode/issue stage of a 16-bit MIPS16-style pipeline.
// Decodes, resolves operands (forward or interlock), loads ID/EX.
module id_issue #(
  parameter int DATA_W = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [15:0]       pc_i,
  input  logic [15:0]       inst_i,
  output logic [3:0]        rf_raddr0_o,
  output logic [3:0]        rf_raddr1_o,
  input  logic [DATA_W-1:0] rf_rdata0_i,
  input  logic [DATA_W-1:0] rf_rdata1_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              hold_i,
  output logic              ex_valid_o,
  output logic [2:0]        ex_aluop_o,
  output logic [DATA_W-1:0] ex_op0_o,
  output logic [DATA_W-1:0] ex_op1_o,
  output logic [DATA_W-1:0] ex_sdata_o,
  output logic              ex_we_o,
  output logic [3:0]        ex_waddr_o,
  output logic              ex_is_load_o,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              branch_flag_o,
  output logic [15:0]       branch_addr_o
);

  typedef enum logic [2:0] {
    ALU_NOP   = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_CMP   = 3'd3,
    ALU_PASS  = 3'd4,
    ALU_LOAD  = 3'd5,
    ALU_STORE = 3'd6
  } aluop_e;

  typedef struct packed {
    logic              valid;
    aluop_e            aluop;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] sdata;
    logic              we;
    logic [3:0]        waddr;
    logic              is_load;
  } id_ex_t;

  localparam logic [4:0] OP_B     = 5'b00010;
  localparam logic [4:0] OP_BEQZ  = 5'b00100;
  localparam logic [4:0] OP_BNEZ  = 5'b00101;
  localparam logic [4:0] OP_ADDIU = 5'b01001;
  localparam logic [4:0] OP_LI    = 5'b01101;
  localparam logic [4:0] OP_LW    = 5'b10011;
  localparam logic [4:0] OP_SW    = 5'b11011;
  localparam logic [4:0] OP_RR    = 5'b11100;
  localparam logic [4:0] OP_CMPG  = 5'b11101;
  localparam logic [3:0] REG_T    = 4'd9;

  id_ex_t ex_q;
  id_ex_t dec;

  logic [4:0] opc;
  logic [3:0] rx;
  logic [3:0] ry;
  logic [3:0] rz;

  assign opc = inst_i[15:11];
  assign rx  = {1'b0, inst_i[10:8]};
  assign ry  = {1'b0, inst_i[7:5]};
  assign rz  = {1'b0, inst_i[4:2]};

  logic [DATA_W-1:0] imm8_s;
  logic [DATA_W-1:0] imm8_z;
  logic [DATA_W-1:0] imm5_s;
  logic [15:0]       off8;
  logic [15:0]       off11;

  assign imm8_s = {{(DATA_W-8){inst_i[7]}}, inst_i[7:0]};
  assign imm8_z = {{(DATA_W-8){1'b0}}, inst_i[7:0]};
  assign imm5_s = {{(DATA_W-5){inst_i[4]}}, inst_i[4:0]};
  assign off8   = {{8{inst_i[7]}}, inst_i[7:0]};
  assign off11  = {{5{inst_i[10]}}, inst_i[10:0]};

  logic is_b;
  logic is_beqz;
  logic is_bnez;
  logic is_addiu;
  logic is_li;
  logic is_lw;
  logic is_sw;
  logic is_addu;
  logic is_subu;
  logic is_cmp;

  assign is_b     = opc == OP_B;
  assign is_beqz  = opc == OP_BEQZ;
  assign is_bnez  = opc == OP_BNEZ;
  assign is_addiu = opc == OP_ADDIU;
  assign is_li    = opc == OP_LI;
  assign is_lw    = opc == OP_LW;
  assign is_sw    = opc == OP_SW;
  assign is_addu  = (opc == OP_RR) && (inst_i[1:0] == 2'b01);
  assign is_subu  = (opc == OP_RR) && (inst_i[1:0] == 2'b11);
  assign is_cmp   = (opc == OP_CMPG) && (inst_i[4:0] == 5'b01010);

  assign rf_raddr0_o = rx;
  assign rf_raddr1_o = ry;

  logic ex_hit0;
  logic ex_hit1;
  logic mem_hit0;
  logic mem_hit1;
  logic ld_hit0;
  logic ld_hit1;

  assign ex_hit0  = ex_q.valid & ex_q.we & (ex_q.waddr == rx);
  assign ex_hit1  = ex_q.valid & ex_q.we & (ex_q.waddr == ry);
  assign mem_hit0 = mem_we_i & (mem_waddr_i == rx);
  assign mem_hit1 = mem_we_i & (mem_waddr_i == ry);
  assign ld_hit0  = ex_q.valid & ex_q.is_load & (ex_q.waddr == rx);
  assign ld_hit1  = ex_q.valid & ex_q.is_load & (ex_q.waddr == ry);

  logic [DATA_W-1:0] opnd0;
  logic [DATA_W-1:0] opnd1;

  // A load in ID/EX has no data yet; it is covered by the load-use stall.
  always_comb begin
    opnd0 = rf_rdata0_i;
    opnd1 = rf_rdata1_i;
    if (FWD_EN) begin
      if (ex_hit0 && !ex_q.is_load) opnd0 = ex_wdata_i;
      else if (mem_hit0)            opnd0 = mem_wdata_i;
      if (ex_hit1 && !ex_q.is_load) opnd1 = ex_wdata_i;
      else if (mem_hit1)            opnd1 = mem_wdata_i;
    end
  end

  logic        use0;
  logic        use1;
  logic        br_al;
  logic        br_z;
  logic        br_nz;
  logic [15:0] br_off;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    use0      = 1'b0;
    use1      = 1'b0;
    br_al     = 1'b0;
    br_z      = 1'b0;
    br_nz     = 1'b0;
    br_off    = 16'h0;
    unique case (1'b1)
      is_b: begin
        br_al  = 1'b1;
        br_off = off11;
      end
      is_beqz: begin
        use0   = 1'b1;
        br_z   = 1'b1;
        br_off = off8;
      end
      is_bnez: begin
        use0   = 1'b1;
        br_nz  = 1'b1;
        br_off = off8;
      end
      is_addiu: begin
        use0      = 1'b1;
        dec.aluop = ALU_ADD;
        dec.op0   = opnd0;
        dec.op1   = imm8_s;
        dec.we    = 1'b1;
        dec.waddr = rx;
      end
      is_li: begin
        dec.aluop = ALU_PASS;
        dec.op0   = imm8_z;
        dec.we    = 1'b1;
        dec.waddr = rx;
      end
      is_lw: begin
        use0        = 1'b1;
        dec.aluop   = ALU_LOAD;
        dec.op0     = opnd0;
        dec.op1     = imm5_s;
        dec.we      = 1'b1;
        dec.waddr   = ry;
        dec.is_load = 1'b1;
      end
      is_sw: begin
        use0      = 1'b1;
        use1      = 1'b1;
        dec.aluop = ALU_STORE;
        dec.op0   = opnd0;
        dec.op1   = imm5_s;
        dec.sdata = opnd1;
      end
      is_addu, is_subu: begin
        use0      = 1'b1;
        use1      = 1'b1;
        dec.aluop = is_subu ? ALU_SUB : ALU_ADD;
        dec.op0   = opnd0;
        dec.op1   = opnd1;
        dec.we    = 1'b1;
        dec.waddr = rz;
      end
      is_cmp: begin
        use0      = 1'b1;
        use1      = 1'b1;
        dec.aluop = ALU_CMP;
        dec.op0   = opnd0;
        dec.op1   = opnd1;
        dec.we    = 1'b1;
        dec.waddr = REG_T;
      end
      default: ;
    endcase
  end

  logic haz_fwd;
  logic haz_lock;
  logic hazard;

  assign haz_fwd  = (use0 & ld_hit0) | (use1 & ld_hit1);
  assign haz_lock = (use0 & (ex_hit0 | mem_hit0))
                  | (use1 & (ex_hit1 | mem_hit1));
  assign hazard   = if_valid_i & (FWD_EN ? haz_fwd : haz_lock);

  assign if_ready_o = !rst & !hazard & !hold_i;

  logic br_cond;

  assign br_cond = br_al
                 | (br_z  & (opnd0 == '0))
                 | (br_nz & (opnd0 != '0));

  assign branch_flag_o = if_ready_o & if_valid_i & br_cond;
  assign branch_addr_o = branch_flag_o ? pc_i + br_off : 16'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!hold_i) begin
      if (hazard || !if_valid_i) ex_q <= '0;
      else                       ex_q <= dec;
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_aluop_o   = ex_q.aluop;
  assign ex_op0_o     = ex_q.op0;
  assign ex_op1_o     = ex_q.op1;
  assign ex_sdata_o   = ex_q.sdata;
  assign ex_we_o      = ex_q.we;
  assign ex_waddr_o   = ex_q.waddr;
  assign ex_is_load_o = ex_q.is_load;

endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: directed vector table plus hand-written hazard sequences.
// Two instances: forwarding (dut) and interlock-only (dut_nf).
module tb_id_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        hold;
  logic [15:0] ex_wdata;
  logic [15:0] rf [16];

  logic        rdy, bflag;
  logic [15:0] baddr;
  logic [3:0]  ra0, ra1;
  logic [15:0] rd0, rd1;
  logic        ex_valid, ex_we, ex_ld;
  logic [2:0]  ex_aluop;
  logic [15:0] ex_op0, ex_op1, ex_sdata;
  logic [3:0]  ex_waddr;

  logic        n_rdy, n_bflag;
  logic [15:0] n_baddr;
  logic [3:0]  n_ra0, n_ra1;
  logic [15:0] n_rd0, n_rd1;
  logic        n_valid, n_we, n_ld;
  logic [2:0]  n_aluop;
  logic [15:0] n_op0, n_op1, n_sdata;
  logic [3:0]  n_waddr;

  assign rd0   = rf[ra0];
  assign rd1   = rf[ra1];
  assign n_rd0 = rf[n_ra0];
  assign n_rd1 = rf[n_ra1];

  logic [63:0] ex_bus, n_bus;
  assign ex_bus = {6'b0, ex_valid, ex_aluop, ex_op0, ex_op1,
                   ex_sdata, ex_we, ex_waddr, ex_ld};
  assign n_bus  = {6'b0, n_valid, n_aluop, n_op0, n_op1,
                   n_sdata, n_we, n_waddr, n_ld};

  id_issue #(.DATA_W(16), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_ready_o(rdy),
    .pc_i(pc), .inst_i(inst),
    .rf_raddr0_o(ra0), .rf_raddr1_o(ra1),
    .rf_rdata0_i(rd0), .rf_rdata1_i(rd1),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .hold_i(hold),
    .ex_valid_o(ex_valid), .ex_aluop_o(ex_aluop),
    .ex_op0_o(ex_op0), .ex_op1_o(ex_op1), .ex_sdata_o(ex_sdata),
    .ex_we_o(ex_we), .ex_waddr_o(ex_waddr), .ex_is_load_o(ex_ld),
    .ex_wdata_i(ex_wdata),
    .branch_flag_o(bflag), .branch_addr_o(baddr)
  );

  id_issue #(.DATA_W(16), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_ready_o(n_rdy),
    .pc_i(pc), .inst_i(inst),
    .rf_raddr0_o(n_ra0), .rf_raddr1_o(n_ra1),
    .rf_rdata0_i(n_rd0), .rf_rdata1_i(n_rd1),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .hold_i(hold),
    .ex_valid_o(n_valid), .ex_aluop_o(n_aluop),
    .ex_op0_o(n_op0), .ex_op1_o(n_op1), .ex_sdata_o(n_sdata),
    .ex_we_o(n_we), .ex_waddr_o(n_waddr), .ex_is_load_o(n_ld),
    .ex_wdata_i(ex_wdata),
    .branch_flag_o(n_bflag), .branch_addr_o(n_baddr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    if_valid = 1'b0;
    mem_we   = 1'b0;
    hold     = 1'b0;
    tick();
  endtask

  task automatic present(input logic [15:0] i, input logic [15:0] p);
    if_valid = 1'b1;
    inst     = i;
    pc       = p;
    #1;
  endtask

  function automatic logic [63:0] exb(
    input logic v, input logic [2:0] op,
    input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] sd,
    input logic we, input logic [3:0] wa, input logic ld);
    return {6'b0, v, op, o0, o1, sd, we, wa, ld};
  endfunction

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
    logic        mwe;
    logic [3:0]  mwa;
    logic [15:0] mwd;
    logic        rdy;
    logic        bf;
    logic [15:0] ba;
    logic [63:0] ex;
  } vec_t;

  localparam int NV = 15;
  localparam logic [15:0] Z = 16'h0;
  vec_t tv [NV];

  logic [63:0] bub_nop;

  initial begin
    bub_nop = exb(1'b1, 3'd0, Z, Z, Z, 1'b0, 4'd0, 1'b0);
    tv[0]  = '{16'h0800, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z, bub_nop};
    tv[1]  = '{16'h6B85, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd4, 16'h0085, Z, Z, 1'b1, 4'd3, 1'b0)};
    tv[2]  = '{16'h4AF0, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd1, 16'h0022, 16'hFFF0, Z, 1'b1, 4'd2, 1'b0)};
    tv[3]  = '{16'h9BBF, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd5, 16'h0033, 16'hFFFF, Z, 1'b1, 4'd5, 1'b1)};
    tv[4]  = '{16'hDCC5, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd6, 16'h0044, 16'h0005, 16'h0066,
                   1'b0, 4'd0, 1'b0)};
    tv[5]  = '{16'hE15D, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd1, 16'h0011, 16'h0022, Z, 1'b1, 4'd7, 1'b0)};
    tv[6]  = '{16'hE6E3, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd2, 16'h0066, 16'h0077, Z, 1'b1, 4'd0, 1'b0)};
    tv[7]  = '{16'hEB8A, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd3, 16'h0033, 16'h0044, Z, 1'b1, 4'd9, 1'b0)};
    tv[8]  = '{16'hE15C, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z, bub_nop};
    tv[9]  = '{16'h17FF, Z, 1'b0, 4'd0, Z, 1'b1, 1'b1, 16'hFFFF, bub_nop};
    tv[10] = '{16'h2910, 16'h0100, 1'b0, 4'd0, Z, 1'b1, 1'b1, 16'h0110,
               bub_nop};
    tv[11] = '{16'h2810, 16'h0100, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z, bub_nop};
    tv[12] = '{16'h4C01, Z, 1'b1, 4'd4, 16'h1234, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd1, 16'h1234, 16'h0001, Z, 1'b1, 4'd4, 1'b0)};
    tv[13] = '{16'hDCC5, Z, 1'b1, 4'd6, 16'hCAFE, 1'b1, 1'b0, Z,
               exb(1'b1, 3'd6, 16'h0044, 16'h0005, 16'hCAFE,
                   1'b0, 4'd0, 1'b0)};
    tv[14] = '{16'hEB8B, Z, 1'b0, 4'd0, Z, 1'b1, 1'b0, Z, bub_nop};

    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 17);
    rst = 1'b1; if_valid = 1'b0; pc = Z; inst = Z;
    mem_we = 1'b0; mem_waddr = 4'd0; mem_wdata = Z;
    hold = 1'b0; ex_wdata = 16'hDEAD;

    #2;
    chk("rst_ex", ex_bus, 64'h0);
    chk("rst_ex_nf", n_bus, 64'h0);
    chk("rst_rdy_br", {rdy, bflag, baddr}, 18'h0);
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bubble();
      mem_we    = tv[i].mwe;
      mem_waddr = tv[i].mwa;
      mem_wdata = tv[i].mwd;
      present(tv[i].inst, tv[i].pc);
      chk($sformatf("v%0d_rdy", i), rdy, tv[i].rdy);
      chk($sformatf("v%0d_bflag", i), bflag, tv[i].bf);
      if (tv[i].bf) chk($sformatf("v%0d_baddr", i), baddr, tv[i].ba);
      tick();
      chk($sformatf("v%0d_ex", i), ex_bus, tv[i].ex);
    end

    // EX-stage forward: LI R1,0x7F then ADDIU R1,1
    bubble();
    present(16'h697F, Z);
    tick();
    chk("li_ex", ex_bus, exb(1'b1, 3'd4, 16'h007F, Z, Z, 1'b1, 4'd1, 1'b0));
    ex_wdata = 16'h007F;
    present(16'h4901, Z);
    chk("fwd_rdy", rdy, 1'b1);
    tick();
    chk("fwd_ex", ex_bus,
        exb(1'b1, 3'd1, 16'h007F, 16'h0001, Z, 1'b1, 4'd1, 1'b0));

    // branch condition sees forwarded value: LI R3,0 then BEQZ R3
    bubble();
    present(16'h6B00, Z);
    tick();
    ex_wdata = 16'h0000;
    present(16'h2304, 16'h0020);
    chk("brfwd_flag", bflag, 1'b1);
    chk("brfwd_addr", baddr, 16'h0024);
    tick();
    ex_wdata = 16'hDEAD;

    // load-use: LW R2,[R3+0] then ADDU R2,R4 -> R5
    bubble();
    present(16'h9B40, Z);
    tick();
    chk("lw_ex", ex_bus, exb(1'b1, 3'd5, 16'h0033, Z, Z, 1'b1, 4'd2, 1'b1));
    present(16'hE295, Z);
    chk("lu_stall", rdy, 1'b0);
    tick();
    chk("lu_bubble", ex_bus, 64'h0);
    mem_we = 1'b1; mem_waddr = 4'd2; mem_wdata = 16'hBEEF;
    #1;
    chk("lu_retry_rdy", rdy, 1'b1);
    tick();
    chk("lu_issue", ex_bus,
        exb(1'b1, 3'd1, 16'hBEEF, 16'h0044, Z, 1'b1, 4'd5, 1'b0));

    // interlock-only: ADDIU R1,5 then SUBU R1,R1,R2
    bubble();
    present(16'h4905, Z);
    tick();
    chk("nf_addiu", n_bus,
        exb(1'b1, 3'd1, 16'h0011, 16'h0005, Z, 1'b1, 4'd1, 1'b0));
    present(16'hE147, Z);
    chk("nf_stall1", n_rdy, 1'b0);
    tick();
    chk("nf_bub1", n_bus, 64'h0);
    mem_we = 1'b1; mem_waddr = 4'd1; mem_wdata = 16'h0016;
    #1;
    chk("nf_stall2", n_rdy, 1'b0);
    tick();
    chk("nf_bub2", n_bus, 64'h0);
    mem_we = 1'b0;
    rf[1] = 16'h0016;
    #1;
    chk("nf_go", n_rdy, 1'b1);
    tick();
    chk("nf_issue", n_bus,
        exb(1'b1, 3'd2, 16'h0016, 16'h0022, Z, 1'b1, 4'd1, 1'b0));
    rf[1] = 16'h0011;

    // BEQZ R0,-2 at 0x0010
    bubble();
    present(16'h20FE, 16'h0010);
    chk("beqz_t_flag", bflag, 1'b1);
    chk("beqz_t_addr", baddr, 16'h000E);
    rf[0] = 16'h0005;
    #1;
    chk("beqz_nt_flag", bflag, 1'b0);
    rf[0] = 16'h0000;
    hold = 1'b1;
    #1;
    chk("beqz_hold_flag", bflag, 1'b0);
    hold = 1'b0;

    // hold during load-use hazard
    bubble();
    present(16'h9B40, Z);
    tick();
    present(16'hE295, Z);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_rdy", c), rdy, 1'b0);
      tick();
      chk($sformatf("hold%0d_ex", c), ex_bus,
          exb(1'b1, 3'd5, 16'h0033, Z, Z, 1'b1, 4'd2, 1'b1));
    end
    hold = 1'b0;
    #1;
    chk("hold_rel_rdy", rdy, 1'b0);
    tick();
    chk("hold_bubble", ex_bus, 64'h0);
    mem_we = 1'b1; mem_waddr = 4'd2; mem_wdata = 16'hBEEF;
    #1;
    chk("hold_retry_rdy", rdy, 1'b1);
    tick();
    chk("hold_issue", ex_bus,
        exb(1'b1, 3'd1, 16'hBEEF, 16'h0044, Z, 1'b1, 4'd5, 1'b0));

    // reset asserted mid-stall
    bubble();
    present(16'h9B40, Z);
    tick();
    present(16'hE295, Z);
    chk("rs_stall", rdy, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_ex", ex_bus, 64'h0);
    chk("rs_ex_nf", n_bus, 64'h0);
    chk("rs_rdy_br", {rdy, bflag, baddr}, 18'h0);
    chk("rs_rdy_br_nf", {n_rdy, n_bflag, n_baddr}, 18'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rs_nohaz", rdy, 1'b1);
    present(16'h0800, Z);
    tick();
    chk("rs_nop", ex_bus, bub_nop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
